// File: rtl/wb_arb_wrr.sv
// rtl/wb_arb_wrr.sv - registered weighted round-robin Wishbone arbiter; optional grant statistics under WB_ARB_WRR_STAT_EN
module wb_arb_wrr #(
    parameter int MASTERS      = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [MASTERS-1:0]              m_cyc_i,
    input  logic [MASTERS*WEIGHT_WIDTH-1:0] cfg_weight_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    input  logic                            bus_hold_i,
    output logic [MASTERS-1:0]              grant_o,
    output logic                            busy_o,
    output logic [MASTERS-1:0]              preempt_o,
    output logic                            bus_hold_ack_o,
    output logic [MASTERS*CNT_WIDTH-1:0]    stat_cnt_o
);

    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [MASTERS-1:0]        grant_q, grant_d;
    logic [MASTERS-1:0]        preempt_q, preempt_d;
    logic                      hold_ack_q, hold_ack_d;
    logic [WEIGHT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                      win_found;
    logic [PW-1:0]             win_idx;
    logic                      owner_cyc;
    logic                      beat;
    logic [WEIGHT_WIDTH-1:0]   owner_weight;
    logic [WEIGHT_WIDTH-1:0]   eff_weight;
    logic [WEIGHT_WIDTH-1:0]   cnt_inc;

    // The pointer holds the current/last owner, so it naturally lands last in its own scan.
    assign owner_cyc    = m_cyc_i[ptr_q];
    assign beat         = s_ack_i | s_err_i | s_rty_i;
    assign owner_weight = cfg_weight_i[int'(ptr_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eff_weight   = (owner_weight == '0) ? WEIGHT_WIDTH'(1) : owner_weight;
    assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + WEIGHT_WIDTH'(1);

    // Round-robin search: first requester from pointer+1 upward, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (!win_found && m_cyc_i[PW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; a hold request wins over pending requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_hold_i) begin
                    state_d = ST_HOLD;
                end else if (win_found) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_cyc) begin
                    if (bus_hold_i) begin
                        state_d = ST_HOLD;
                    end else if (win_found) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus_hold_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and beat counter.
    always_comb begin
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        preempt_d  = preempt_q;
        cnt_d      = cnt_q;
        hold_ack_d = (state_d == ST_HOLD);
        case (state_q)
            ST_IDLE: begin
                if (!bus_hold_i && win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ptr_d            = win_idx;
                    cnt_d            = '0;
                    preempt_d        = '0;
                end
            end
            ST_GRANT: begin
                if (owner_cyc) begin
                    // Preempt is sticky for the tenure; weight is sampled only on beats.
                    if (beat) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= eff_weight) begin
                            preempt_d[ptr_q] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d     = '0;
                    preempt_d = '0;
                    if (!bus_hold_i && win_found) begin
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        ptr_d            = win_idx;
                    end else begin
                        grant_d = '0;
                    end
                end
            end
            ST_HOLD: begin
                grant_d = '0;
            end
            default: begin
                grant_d   = '0;
                preempt_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    // Datapath registers; master 0 has first priority out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= PW'(MASTERS - 1);
            grant_q    <= '0;
            preempt_q  <= '0;
            hold_ack_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            preempt_q  <= preempt_d;
            hold_ack_q <= hold_ack_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant_o        = grant_q;
    assign busy_o         = |grant_q;
    assign preempt_o      = preempt_q;
    assign bus_hold_ack_o = hold_ack_q;

`ifdef WB_ARB_WRR_STAT_EN
    logic [CNT_WIDTH-1:0] stat_q [MASTERS];

    // A master is newly granted when its grant bit rises; an owner can never be re-granted back-to-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < MASTERS; m++) begin
                stat_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < MASTERS; m++) begin
                if (grant_d[m] && !grant_q[m] && (stat_q[m] != '1)) begin
                    stat_q[m] <= stat_q[m] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < MASTERS; g++) begin : g_stat
        assign stat_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = stat_q[g];
    end
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_arb_wrr.sv
// tb/tb_wb_arb_wrr.sv - scoreboard bench for wb_arb_wrr
module tb_wb_arb_wrr;
    localparam int M  = 4;
    localparam int WW = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [M-1:0]      m_cyc;
    logic [M*WW-1:0]   cfg_weight;
    logic              s_ack, s_err, s_rty, bus_hold;
    logic [M-1:0]      grant, preempt;
    logic              busy, hold_ack;
    logic [M*CW-1:0]   stat_cnt;

    int checks = 0;
    int errors = 0;
    logic [M-1:0] exp_q [$];
    logic [M-1:0] exp_v;

    wb_arb_wrr #(.MASTERS(M), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .m_cyc_i        (m_cyc),
        .cfg_weight_i   (cfg_weight),
        .s_ack_i        (s_ack),
        .s_err_i        (s_err),
        .s_rty_i        (s_rty),
        .bus_hold_i     (bus_hold),
        .grant_o        (grant),
        .busy_o         (busy),
        .preempt_o      (preempt),
        .bus_hold_ack_o (hold_ack),
        .stat_cnt_o     (stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_cyc      = '0;
        s_ack      = 1'b0;
        s_err      = 1'b0;
        s_rty      = 1'b0;
        bus_hold   = 1'b0;
        cfg_weight = {M{4'd2}};
        rst_n      = 1'b0;
        tick();
        rst_n      = 1'b1;
    endtask

    task automatic test_reset();
        m_cyc = '0; s_ack = 0; s_err = 0; s_rty = 0; bus_hold = 0;
        cfg_weight = {M{4'd2}};
        rst_n = 1'b0;
        #3;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        checks++; if (preempt !== 4'b0000) begin errors++; $display("FAIL reset_preempt: got %b expected %b", preempt, 4'b0000); end
        checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL reset_hold_ack: got %b expected %b", hold_ack, 1'b0); end
        checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL reset_stat: got %h expected 0", stat_cnt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        m_cyc = 4'b0001;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        tick();
        exp_v = exp_q.pop_front();
        checks++; if (grant !== exp_v) begin errors++; $display("FAIL single_grant: got %b expected %b", grant, exp_v); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected %b", busy, 1'b1); end
        m_cyc = 4'b0000;
        tick();
        exp_v = exp_q.pop_front();
        checks++; if (grant !== exp_v) begin errors++; $display("FAIL single_release: got %b expected %b", grant, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_back_to_back();
        logic [M-1:0] cur;
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        m_cyc = 4'b1111;
        tick();
        cur = exp_q.pop_front();
        checks++; if (grant !== cur) begin errors++; $display("FAIL rr_first: got %b expected %b", grant, cur); end
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1;
            tick();
            tick();
            s_ack = 1'b0;
            m_cyc = 4'b1111 & ~cur;
            tick();
            m_cyc = 4'b1111;
            cur = exp_q.pop_front();
            checks++; if (grant !== cur) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b", k, grant, cur); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_no_idle_%0d: got %b expected %b", k, busy, 1'b1); end
            checks++; if (!$onehot0(grant) || (hold_ack && grant != 0)) begin errors++; $display("FAIL rr_invariant_%0d: got grant %b ack %b expected one-hot grant and no ack", k, grant, hold_ack); end
        end
        m_cyc = '0;
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        cfg_weight[7:4] = 4'd3;
        m_cyc = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pre_grant: got %b expected %b", grant, 4'b0010); end
        s_ack = 1'b1;
        tick();
        tick();
        checks++; if (preempt !== 4'b0000) begin errors++; $display("FAIL pre_after2: got %b expected %b", preempt, 4'b0000); end
        tick();
        s_ack = 1'b0;
        checks++; if (preempt !== 4'b0010) begin errors++; $display("FAIL pre_after3: got %b expected %b", preempt, 4'b0010); end
        tick();
        checks++; if (preempt !== 4'b0010) begin errors++; $display("FAIL pre_held: got %b expected %b", preempt, 4'b0010); end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pre_grant_kept: got %b expected %b", grant, 4'b0010); end
        m_cyc = 4'b0000;
        tick();
        checks++; if (preempt !== 4'b0000) begin errors++; $display("FAIL pre_cleared: got %b expected %b", preempt, 4'b0000); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL pre_release: got %b expected %b", grant, 4'b0000); end
        cfg_weight[7:4] = 4'd0;
        m_cyc = 4'b0010;
        tick();
        s_err = 1'b1;
        tick();
        s_err = 1'b0;
        checks++; if (preempt !== 4'b0010) begin errors++; $display("FAIL pre_weight0: got %b expected %b", preempt, 4'b0010); end
        m_cyc = 4'b0000;
        tick();
    endtask

    task automatic test_hold_idle();
        do_reset();
        bus_hold = 1'b1;
        m_cyc = 4'b0100;
        tick();
        checks++; if (hold_ack !== 1'b1) begin errors++; $display("FAIL hold_idle_ack: got %b expected %b", hold_ack, 1'b1); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL hold_idle_grant: got %b expected %b", grant, 4'b0000); end
        bus_hold = 1'b0;
        tick();
        checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL hold_idle_release: got %b expected %b", hold_ack, 1'b0); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL hold_idle_gap: got %b expected %b", grant, 4'b0000); end
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_idle_regrant: got %b expected %b", grant, 4'b0100); end
        m_cyc = '0;
        tick();
    endtask

    task automatic test_hold_owner();
        do_reset();
        m_cyc = 4'b0100;
        tick();
        bus_hold = 1'b1;
        tick();
        tick();
        checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL hold_own_noack: got %b expected %b", hold_ack, 1'b0); end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_own_grant: got %b expected %b", grant, 4'b0100); end
        m_cyc = 4'b0000;
        tick();
        checks++; if (hold_ack !== 1'b1) begin errors++; $display("FAIL hold_own_ack: got %b expected %b", hold_ack, 1'b1); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL hold_own_grant0: got %b expected %b", grant, 4'b0000); end
        bus_hold = 1'b0;
        tick();
        checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL hold_own_release: got %b expected %b", hold_ack, 1'b0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_weight[15:12] = 4'd0;
        m_cyc = 4'b1000;
        tick();
        s_rty = 1'b1;
        tick();
        s_rty = 1'b0;
        checks++; if (preempt !== 4'b1000) begin errors++; $display("FAIL mid_preempt: got %b expected %b", preempt, 4'b1000); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b expected %b", grant, 4'b0000); end
        checks++; if (preempt !== 4'b0000) begin errors++; $display("FAIL mid_preempt0: got %b expected %b", preempt, 4'b0000); end
        checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL mid_hold_ack: got %b expected %b", hold_ack, 1'b0); end
        checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL mid_stat: got %h expected 0", stat_cnt); end
        m_cyc = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stat();
        logic [CW-1:0] exp3;
        do_reset();
`ifdef WB_ARB_WRR_STAT_EN
        exp3 = CW'(5);
`else
        exp3 = '0;
`endif
        for (int k = 0; k < 5; k++) begin
            m_cyc = 4'b1000;
            tick();
            m_cyc = 4'b0000;
            tick();
        end
        checks++; if (stat_cnt[3*CW +: CW] !== exp3) begin errors++; $display("FAIL stat_m3: got %0d expected %0d", stat_cnt[3*CW +: CW], exp3); end
        checks++; if (stat_cnt[3*CW-1:0] !== '0) begin errors++; $display("FAIL stat_others: got %h expected 0", stat_cnt[3*CW-1:0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_hold_idle();
        test_hold_owner();
        test_reset_mid();
        test_stat();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
